// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: raw key levels in, debounced state and event pulses out.
interface key_debounce_multi_if #(
   parameter int N_KEYS = 4
);
   logic [N_KEYS-1:0] key_in;
   logic [N_KEYS-1:0] key_out;
   logic [N_KEYS-1:0] press_pulse;
   logic [N_KEYS-1:0] release_pulse;
   logic [N_KEYS-1:0] long_press;
   modport master (output key_in, input key_out, press_pulse, release_pulse, long_press);
   modport slave (input key_in, output key_out, press_pulse, release_pulse, long_press);
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel synchronise, debounce, press/release pulses and long-press detection.
module key_debounce_multi #(
   parameter int N_KEYS      = 4,
   parameter int SAMPLE_TIME = 4,
   parameter int LONG_TIME   = 1000000,
   parameter int CNT_W       = 22,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   key_debounce_multi_if.slave    kb
);
   localparam logic REL = (ACTIVE_LOW != 0);
   logic [N_KEYS-1:0] sync1, sync2, s;
   // Synchronisers idle at the released raw level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= {N_KEYS{REL}};
         sync2 <= {N_KEYS{REL}};
         s     <= '0;
      end else begin
         sync1 <= kb.key_in;
         sync2 <= sync1;
         s     <= REL ? ~sync2 : sync2;
      end
   end
   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      logic [CNT_W-1:0] db_cnt, hold_cnt;
      logic ko, pp, rp, lp, diff, hit;
      always_comb begin
         diff = s[i] ^ ko;
         hit  = diff && (db_cnt == CNT_W'(SAMPLE_TIME - 1));
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            db_cnt   <= '0;
            hold_cnt <= '0;
            ko       <= 1'b0;
            pp       <= 1'b0;
            rp       <= 1'b0;
            lp       <= 1'b0;
         end else begin
            db_cnt   <= (diff && !hit) ? db_cnt + 1'b1 : '0;
            ko       <= hit ? s[i] : ko;
            pp       <= hit && s[i];
            rp       <= hit && !s[i];
            hold_cnt <= !ko ? '0 : (hold_cnt == CNT_W'(LONG_TIME)) ? hold_cnt : hold_cnt + 1'b1;
            lp       <= ko && (hold_cnt == CNT_W'(LONG_TIME - 1));
         end
      end
      assign kb.key_out[i]       = ko;
      assign kb.press_pulse[i]   = pp;
      assign kb.release_pulse[i] = rp;
      assign kb.long_press[i]    = lp;
   end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: table-driven key scenarios checked cycle by cycle against a scoreboard of expected events.
module tb_key_debounce_multi;
   localparam int N = 4, ST = 4, LT = 20, CW = 8;
   localparam int LAT = ST + 3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   key_debounce_multi_if #(.N_KEYS(N)) bus ();
   key_debounce_multi_if #(.N_KEYS(N)) bus2 ();
   key_debounce_multi #(.N_KEYS(N), .SAMPLE_TIME(ST), .LONG_TIME(LT), .CNT_W(CW), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .kb(bus.slave));
   key_debounce_multi #(.N_KEYS(N), .SAMPLE_TIME(ST), .LONG_TIME(LT), .CNT_W(CW), .ACTIVE_LOW(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .kb(bus2.slave));
   typedef struct {int cyc; logic [3:0] pr; logic [3:0] rl; logic [3:0] lg;} ev_t;
   typedef struct {logic [3:0] keys; int hold; bit press; bit lng;} vec_t;
   ev_t sb[$];
   vec_t tv[7];
   logic [3:0] ep, er, el, exp_ko = '0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
      ev_t e;
      e.cyc = c; e.pr = pr; e.rl = rl; e.lg = lg;
      sb.push_back(e);
   endtask
   // Every cycle, outputs must match exactly the events due now; anything unscheduled must be quiet.
   always @(negedge clk) begin
      ep = '0; er = '0; el = '0;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].cyc == cyc) begin
            ep |= sb[i].pr; er |= sb[i].rl; el |= sb[i].lg;
            sb.delete(i);
         end
      exp_ko = !rst_n ? 4'b0 : (exp_ko | ep) & ~er;
      chk("outs", {16'h0, bus.key_out, bus.press_pulse, bus.release_pulse, bus.long_press},
          {16'h0, exp_ko, ep, er, el});
   end
   initial begin
      int k, r, np, pc, oth;
      tv[0] = '{4'b0001, 30, 1'b1, 1'b1};
      tv[1] = '{4'b0010, 3,  1'b0, 1'b0};
      tv[2] = '{4'b0100, 10, 1'b1, 1'b0};
      tv[3] = '{4'b1001, 21, 1'b1, 1'b1};
      tv[4] = '{4'b0100, 19, 1'b1, 1'b0};
      tv[5] = '{4'b1111, 4,  1'b1, 1'b0};
      tv[6] = '{4'b0010, 1,  1'b0, 1'b0};
      bus.key_in = '1;
      bus2.key_in = '0;
      step(3);
      rst_n = 1'b1;
      step(5);
      foreach (tv[v]) begin
         k = cyc;
         bus.key_in = ~tv[v].keys;
         if (tv[v].press) begin
            push(k + LAT, tv[v].keys, 4'b0, 4'b0);
            push(k + tv[v].hold + LAT, 4'b0, tv[v].keys, 4'b0);
         end
         if (tv[v].lng) push(k + LAT + LT, 4'b0, 4'b0, tv[v].keys);
         step(tv[v].hold);
         bus.key_in = '1;
         step(40);
      end
      // Reset in the middle of a hold aborts it; the still-pressed key re-debounces afterwards.
      k = cyc;
      bus.key_in = 4'b1101;
      push(k + LAT, 4'b0010, 4'b0, 4'b0);
      step(12);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      r = cyc;
      push(r + LAT, 4'b0010, 4'b0, 4'b0);
      step(10);
      bus.key_in = '1;
      push(cyc + LAT, 4'b0, 4'b0010, 4'b0);
      step(40);
      // Active-high channel with chatter before settling.
      foreach (tv[v]) if (v < 4) begin
         bus2.key_in[0] = (v % 2 == 0);
         step(1);
      end
      bus2.key_in[0] = 1'b1;
      k = cyc;
      np = 0; pc = -1; oth = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (bus2.press_pulse[0]) begin np++; pc = cyc; end
         if (bus2.press_pulse[3:1] != 0 || bus2.release_pulse != 0 || bus2.long_press != 0) oth++;
      end
      chk("chatter_presses", np, 1);
      chk("chatter_latency", pc, k + LAT);
      chk("chatter_quiet", oth, 0);
      chk("chatter_key_out", {28'h0, bus2.key_out}, 32'h1);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_debounce_multi.md
KEY_DEBOUNCE_MULTI -- requirements
Module: key_debounce_multi

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels (1..32).
REQ-002 Parameter SAMPLE_TIME, default 4, consecutive stable cycles required to accept a level change (>=1).
REQ-003 Parameter LONG_TIME, default 1000000, cycles a debounced press is held before long-press is flagged (> SAMPLE_TIME).
REQ-004 Parameter CNT_W, default 22, width of every per-channel counter; SHALL satisfy 2^CNT_W > LONG_TIME.
REQ-005 Parameter ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed, 0 = raw key reads 1 when pressed.
REQ-006 clk  input  1  single system clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 key_in  input  N_KEYS  raw asynchronous key levels, bit i = channel i.
REQ-009 key_out  output  N_KEYS  debounced logical state, 1 = pressed (polarity normalised).
REQ-010 press_pulse  output  N_KEYS  one-cycle pulse on accepted press.
REQ-011 release_pulse  output  N_KEYS  one-cycle pulse on accepted release.
REQ-012 long_press  output  N_KEYS  one-cycle pulse when a press has lasted LONG_TIME cycles.

Function
REQ-013 Each key_in bit SHALL pass through a 2-flop synchroniser, then be normalised to logical s_i = pressed ? 1 : 0 per ACTIVE_LOW.
REQ-014 Channels SHALL be fully independent; activity on one channel SHALL NOT affect another's counters or outputs.
REQ-015 Per channel, a debounce counter SHALL increment each cycle s_i != key_out[i] and clear to 0 any cycle s_i == key_out[i].
REQ-016 On the edge where the debounce counter would reach SAMPLE_TIME, key_out[i] SHALL take s_i and the counter SHALL clear.
REQ-017 Latency: a clean raw transition SHALL appear on key_out exactly 2 + SAMPLE_TIME cycles after the first sampling edge seeing the new level.
REQ-018 Any glitch shorter than SAMPLE_TIME synchronised cycles SHALL leave key_out unchanged and produce no pulses.
REQ-019 press_pulse[i] SHALL be high for exactly the one cycle in which key_out[i] first reads 1 after a 0->1 update; release_pulse[i] likewise for 1->0.
REQ-020 A hold counter SHALL clear when key_out[i] is 0, increment each cycle key_out[i] is 1, and saturate at LONG_TIME (no wrap).
REQ-021 long_press[i] SHALL pulse for one cycle when the hold counter reaches LONG_TIME; at most one long_press per press, none after release.
REQ-022 A release accepted before LONG_TIME SHALL clear the hold counter and suppress long_press for that press.
REQ-023 press_pulse and release_pulse SHALL never be high simultaneously on one channel; pulses on different channels MAY coincide.

Reset
REQ-024 While rst_n = 0: synchroniser flops at the released raw level, s = 0, key_out = 0, all pulses = 0, all counters = 0.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort it; after release of rst_n a key already pressed SHALL produce press_pulse after 2 + SAMPLE_TIME cycles.
REQ-026 Outputs SHALL be registered; no combinational path from key_in to any output.

Verification (SAMPLE_TIME=4, LONG_TIME=20, N_KEYS=4, ACTIVE_LOW=1)
REQ-027 key_in[0] 1->0 held 30 cycles -> key_out[0] rises 6 cycles later, press_pulse[0] one cycle there, long_press[0] one cycle 20 cycles after key_out rise, none afterwards.
REQ-028 key_in[1] low for 3 cycles then high -> key_out[1] stays 0, no pulses on any channel.
REQ-029 key_in[2] pressed 10 cycles then released -> press_pulse then release_pulse 10 cycles apart, no long_press.
REQ-030 key_in[0] and key_in[3] pressed same cycle -> press_pulse[0] and press_pulse[3] high in same cycle, other channels quiet.
REQ-031 Hold key_in[1] low, assert rst_n for 2 cycles mid-hold -> all outputs 0 during reset; press_pulse[1] 6 cycles after reset release.
REQ-032 ACTIVE_LOW=0, key_in[0] 0->1 chatter (1,0,1,0) then stable 1 -> single press_pulse[0] 6 cycles after stable level begins.
